// File: rtl/simd_alu_addsub_pipe.sv
// Two-stage pipelined SIMD add/subtract with 8/16/32/64-bit lanes, signed/unsigned,
// wrap/saturate modes and per-lane overflow flags; valid/ready on both sides.
module simd_alu_addsub_pipe #(
  parameter int unsigned SIMD_DATA_WIDTH = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SIMD_DATA_WIDTH-1:0]   a,
  input  logic [SIMD_DATA_WIDTH-1:0]   b,
  input  logic [1:0]                   data_mode,
  input  logic                         data_signed,
  input  logic                         op_sub,
  input  logic                         saturate,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SIMD_DATA_WIDTH-1:0]   result,
  output logic [SIMD_DATA_WIDTH/8-1:0] ovf_flags
);

  localparam int unsigned NUM_BYTES = SIMD_DATA_WIDTH / 8;

  typedef struct packed {
    logic [1:0] mode;
    logic       sgn;
    logic       sub;
    logic       sat;
  } ctrl_t;

  // Handshake / stage advance
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_adv, s2_adv, s1_load, s2_load;

  assign s2_adv     = !s2_valid_q || out_ready;
  assign s1_adv     = !s1_valid_q || s2_adv;
  assign in_ready   = s1_adv;
  assign s1_load    = s1_adv && in_valid;
  assign s2_load    = s2_adv && s1_valid_q;
  assign s1_valid_d = s1_adv ? in_valid : s1_valid_q;
  assign s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;

  // Stage 1 payload: raw lane sums, per-byte carry-out and operand sign bits
  ctrl_t                      s1_ctrl_q, s1_ctrl_d;
  logic [SIMD_DATA_WIDTH-1:0] s1_sum_q, s1_sum_d;
  logic [NUM_BYTES-1:0]       s1_cout_q, s1_cout_d;
  logic [NUM_BYTES-1:0]       s1_asgn_q, s1_asgn_d;
  logic [NUM_BYTES-1:0]       s1_bsgn_q, s1_bsgn_d;

  assign s1_ctrl_d = '{mode: data_mode, sgn: data_signed, sub: op_sub, sat: saturate};

  logic [8:0]  byte_sum;
  logic        carry, cin;
  int unsigned lane_mask;

  // Byte-sliced ripple adder; carry chain restarts at each lane's lowest byte
  always_comb begin : s1_adder
    s1_sum_d  = '0;
    s1_cout_d = '0;
    s1_asgn_d = '0;
    s1_bsgn_d = '0;
    byte_sum  = '0;
    carry     = 1'b0;
    cin       = 1'b0;
    lane_mask = (32'd1 << data_mode) - 32'd1;
    for (int unsigned j = 0; j < NUM_BYTES; j++) begin
      cin = ((j & lane_mask) == 32'd0) ? op_sub : carry;
      byte_sum = {1'b0, a[j*8 +: 8]} + {1'b0, b[j*8 +: 8] ^ {8{op_sub}}} + {8'd0, cin};
      s1_sum_d[j*8 +: 8] = byte_sum[7:0];
      s1_cout_d[j]       = byte_sum[8];
      s1_asgn_d[j]       = a[j*8+7];
      s1_bsgn_d[j]       = b[j*8+7];
      carry              = byte_sum[8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : s1_regs
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ctrl_q  <= '0;
      s1_sum_q   <= '0;
      s1_cout_q  <= '0;
      s1_asgn_q  <= '0;
      s1_bsgn_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_ctrl_q <= s1_ctrl_d;
        s1_sum_q  <= s1_sum_d;
        s1_cout_q <= s1_cout_d;
        s1_asgn_q <= s1_asgn_d;
        s1_bsgn_q <= s1_bsgn_d;
      end
    end
  end

  // Stage 2: overflow detection from each lane's top byte, then clamp per byte
  logic [SIMD_DATA_WIDTH-1:0] result_q, result_d;
  logic [NUM_BYTES-1:0]       flags_q, flags_d;
  int unsigned                bpl, lo, hi;
  logic                       ovf, sa, sb, sr;
  logic [7:0]                 sat_byte;

  always_comb begin : s2_saturate
    result_d = '0;
    flags_d  = '0;
    lo       = 0;
    hi       = 0;
    ovf      = 1'b0;
    sa       = 1'b0;
    sb       = 1'b0;
    sr       = 1'b0;
    sat_byte = '0;
    bpl      = 32'd1 << s1_ctrl_q.mode;
    for (int unsigned j = 0; j < NUM_BYTES; j++) begin
      lo = j & ~(bpl - 32'd1);
      hi = lo + bpl - 32'd1;
      sa = s1_asgn_q[hi];
      sb = s1_bsgn_q[hi];
      sr = s1_sum_q[hi*8+7];
      if (s1_ctrl_q.sgn) begin
        ovf      = (s1_ctrl_q.sub ? (sa != sb) : (sa == sb)) && (sr != sa);
        sat_byte = sa ? ((j == hi) ? 8'h80 : 8'h00) : ((j == hi) ? 8'h7F : 8'hFF);
      end else begin
        ovf      = s1_ctrl_q.sub ? !s1_cout_q[hi] : s1_cout_q[hi];
        sat_byte = s1_ctrl_q.sub ? 8'h00 : 8'hFF;
      end
      result_d[j*8 +: 8] = (ovf && s1_ctrl_q.sat) ? sat_byte : s1_sum_q[j*8 +: 8];
      flags_d[j]         = ovf && (j == lo);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : s2_regs
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign ovf_flags = flags_q;

endmodule

// File: tb/tb_simd_alu_addsub_pipe.sv
// Self-checking bench for simd_alu_addsub_pipe: directed vectors, backpressure,
// randomized traffic against a lane-arithmetic reference model, and mid-stream reset.
module tb_simd_alu_addsub_pipe;

  localparam int unsigned DW = 256;
  localparam int unsigned NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic [1:0]    data_mode = '0;
  logic          data_signed = 1'b0;
  logic          op_sub = 1'b0;
  logic          saturate = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] result;
  logic [NB-1:0] ovf_flags;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DW-1:0] r;
    logic [NB-1:0] f;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  simd_alu_addsub_pipe #(.SIMD_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .data_mode(data_mode), .data_signed(data_signed),
    .op_sub(op_sub), .saturate(saturate), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .ovf_flags(ovf_flags)
  );

  // Reference: each lane evaluated as plain integers, overflow = out of representable range
  function automatic exp_t model(input logic [DW-1:0] av_i, input logic [DW-1:0] bv_i,
                                 input logic [1:0] mode, input logic sgn, input logic sub,
                                 input logic sat);
    exp_t              e;
    int                w, n;
    logic [63:0]       mask, av, bv, rv;
    logic [64:0]       full;
    logic signed [65:0] sa, sb, sr, mx, mn;
    logic              ov;
    e = '0;
    w = 8 << mode;
    n = DW / w;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    for (int i = 0; i < n; i++) begin
      av = 64'(av_i >> (i * w)) & mask;
      bv = 64'(bv_i >> (i * w)) & mask;
      if (!sgn) begin
        if (!sub) begin
          full = {1'b0, av} + {1'b0, bv};
          ov = full > {1'b0, mask};
          rv = (ov && sat) ? mask : (full[63:0] & mask);
        end else begin
          ov = av < bv;
          rv = (ov && sat) ? 64'd0 : ((av - bv) & mask);
        end
      end else begin
        sa = $signed({2'b00, av});
        sb = $signed({2'b00, bv});
        if (av[w-1]) sa = sa - (66'sd1 <<< w);
        if (bv[w-1]) sb = sb - (66'sd1 <<< w);
        mx = (66'sd1 <<< (w - 1)) - 66'sd1;
        mn = -(66'sd1 <<< (w - 1));
        sr = sub ? (sa - sb) : (sa + sb);
        ov = (sr > mx) || (sr < mn);
        if (ov && sat) rv = ((sr > mx) ? 64'(mx) : 64'(mn)) & mask;
        else           rv = 64'(sr) & mask;
      end
      e.r = e.r | (DW'(rv) << (i * w));
      e.f[i * w / 8] = ov;
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < NB; k++) begin
      case ($urandom_range(0, 7))
        0:       v[k*8 +: 8] = 8'hFF;
        1:       v[k*8 +: 8] = 8'h00;
        2:       v[k*8 +: 8] = 8'h7F;
        3:       v[k*8 +: 8] = 8'h80;
        default: v[k*8 +: 8] = 8'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic drive_rand();
    in_valid    = 1'b1;
    a           = rand_vec();
    b           = rand_vec();
    data_mode   = 2'($urandom_range(0, 3));
    data_signed = 1'($urandom_range(0, 1));
    op_sub      = 1'($urandom_range(0, 1));
    saturate    = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || ovf_flags !== '0) begin
      errors++;
      $display("FAIL reset_state out_valid=%b result=%h flags=%h", out_valid, result, ovf_flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [DW-1:0] er;
    logic [NB-1:0] ef;
    for (int k = 0; k < 9; k++) begin
      case (k)
        0: begin a = '1; b = {NB{8'h01}}; data_mode = 2'd0; data_signed = 0; op_sub = 0; saturate = 0;
                 er = '0; ef = '1; end
        1: begin a = 256'hF0; b = 256'h20; data_mode = 2'd0; data_signed = 0; op_sub = 0; saturate = 1;
                 er = 256'hFF; ef = 32'h1; end
        2: begin a = 256'hF0; b = 256'h20; data_mode = 2'd0; data_signed = 1; op_sub = 0; saturate = 1;
                 er = 256'h10; ef = 32'h0; end
        3: begin a = 256'h7FFF_8000; b = 256'hFFFF_0001; data_mode = 2'd1; data_signed = 1; op_sub = 1; saturate = 1;
                 er = 256'h7FFF_8000; ef = 32'h5; end
        4: begin a = 256'h7FFF_8000; b = 256'hFFFF_0001; data_mode = 2'd1; data_signed = 1; op_sub = 1; saturate = 0;
                 er = 256'h8000_7FFF; ef = 32'h5; end
        5: begin a = 256'hFFFF_FFFF_FFFF_FFFF; b = 256'h1; data_mode = 2'd3; data_signed = 0; op_sub = 0; saturate = 0;
                 er = '0; ef = 32'h1; end
        6: begin a = 256'h5; b = 256'h7; data_mode = 2'd2; data_signed = 0; op_sub = 1; saturate = 1;
                 er = '0; ef = 32'h1; end
        7: begin a = 256'h7FFF_FFFF; b = 256'h1; data_mode = 2'd2; data_signed = 1; op_sub = 0; saturate = 1;
                 er = 256'h7FFF_FFFF; ef = 32'h1; end
        default: begin a = 256'h7FFF_FFFF; b = 256'h1; data_mode = 2'd2; data_signed = 1; op_sub = 0; saturate = 0;
                 er = 256'h8000_0000; ef = 32'h1; end
      endcase
      @(negedge clk);
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_accept in_ready=%b exp 1", k, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_early out_valid=%b exp 0 one cycle after accept", k, out_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || result !== er || ovf_flags !== ef) begin
        errors++;
        $display("FAIL dir%0d_data out_valid=%b result=%h flags=%h exp result=%h flags=%h",
                 k, out_valid, result, ovf_flags, er, ef);
      end
    end
  endtask

  task automatic test_backpressure();
    int   sent = 0;
    int   got = 0;
    logic pending = 1'b0;
    logic held = 1'b0;
    exp_t e, hold_e;
    hold_e = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (sent < 5) begin
        if (!pending) drive_rand();
        pending = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (c >= 4);
      #1;
      checks++;
      if (in_ready !== ((q.size() < 2) || out_ready)) begin
        errors++;
        $display("FAIL bp_in_ready cycle=%0d got=%b occupancy=%0d out_ready=%b", c, in_ready, q.size(), out_ready);
      end
      if (c == 3) begin
        checks++;
        if (sent != 2) begin
          errors++;
          $display("FAIL bp_accepted_while_stalled got=%0d exp 2", sent);
        end
      end
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || result !== hold_e.r || ovf_flags !== hold_e.f) begin
          errors++;
          $display("FAIL bp_hold out_valid=%b result=%h exp %h", out_valid, result, hold_e.r);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        got++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL bp_spurious_output result=%h", result);
        end else begin
          e = q.pop_front();
          if (result !== e.r || ovf_flags !== e.f) begin
            errors++;
            $display("FAIL bp_data result=%h flags=%h exp result=%h flags=%h", result, ovf_flags, e.r, e.f);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(model(a, b, data_mode, data_signed, op_sub, saturate));
        sent++;
        pending = 1'b0;
      end
      held = (out_valid === 1'b1) && !out_ready;
      hold_e.r = result;
      hold_e.f = ovf_flags;
      if (sent == 5 && got == 5) break;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 5 || q.size() != 0) begin
      errors++;
      $display("FAIL bp_count received=%0d exp 5 leftover=%0d", got, q.size());
    end
  endtask

  task automatic test_random();
    logic held = 1'b0;
    exp_t e, hold_e;
    hold_e = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c < 560 && $urandom_range(0, 3) != 0) drive_rand();
      else in_valid = 1'b0;
      out_ready = (c >= 560) || ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (in_ready !== ((q.size() < 2) || out_ready)) begin
        errors++;
        $display("FAIL rand_in_ready cycle=%0d got=%b occupancy=%0d out_ready=%b", c, in_ready, q.size(), out_ready);
      end
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || result !== hold_e.r || ovf_flags !== hold_e.f) begin
          errors++;
          $display("FAIL rand_hold cycle=%0d out_valid=%b result=%h exp %h", c, out_valid, result, hold_e.r);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious_output cycle=%0d result=%h", c, result);
        end else begin
          e = q.pop_front();
          if (result !== e.r || ovf_flags !== e.f) begin
            errors++;
            $display("FAIL rand_data cycle=%0d result=%h flags=%h exp result=%h flags=%h",
                     c, result, ovf_flags, e.r, e.f);
          end
        end
      end
      if (in_valid && in_ready === 1'b1)
        q.push_back(model(a, b, data_mode, data_signed, op_sub, saturate));
      held = (out_valid === 1'b1) && !out_ready;
      hold_e.r = result;
      hold_e.f = ovf_flags;
    end
    in_valid = 1'b0;
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain leftover=%0d out_valid=%b exp 0/0", q.size(), out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      drive_rand();
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_full out_valid=%b in_ready=%b exp 1/0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || ovf_flags !== '0) begin
      errors++;
      $display("FAIL mid_async_clear out_valid=%b result=%h flags=%h exp zeros", out_valid, result, ovf_flags);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    a = '1; b = {NB{8'h01}}; data_mode = 2'd0; data_signed = 0; op_sub = 0; saturate = 0;
    @(negedge clk);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_after_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_early out_valid=%b exp 0", out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || result !== '0 || ovf_flags !== '1) begin
      errors++;
      $display("FAIL mid_first_txn out_valid=%b result=%h flags=%h exp 1/0/all-ones", out_valid, result, ovf_flags);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/simd_alu_addsub_pipe.md
Name: simd_alu_addsub_pipe

Overview:
- Pipelined SIMD add/subtract unit; successor to the combinational SIMD adder in the ALU datapath.
- Lane widths: 8/16/32/64 bits, selected per transaction.
- Modes: signed/unsigned, wrap/saturate, add/sub. Produces per-lane overflow flags.
- Sits between the ALU operand issue stage and writeback; valid/ready handshake on both sides.

Parameters:
- SIMD_DATA_WIDTH, 256, vector width in bits; must be a multiple of 64.
- NUM_BYTES, SIMD_DATA_WIDTH/8, derived (localparam); width of the flag vector.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand transaction valid
- in_ready  out  1  unit can accept a transaction this cycle
- a  in  SIMD_DATA_WIDTH  operand A
- b  in  SIMD_DATA_WIDTH  operand B
- data_mode  in  2  lane width: 0=8, 1=16, 2=32, 3=64
- data_signed  in  1  1 = two's complement lanes
- op_sub  in  1  1 = a-b, 0 = a+b
- saturate  in  1  1 = clamp on overflow, 0 = wrap
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  SIMD_DATA_WIDTH  lane results
- ovf_flags  out  NUM_BYTES  per-lane overflow flag

Behaviour:
- Reset: rst_n low asynchronously clears both pipeline valid bits, result, ovf_flags and all stage registers to 0.
  - Reset mid-operation discards in-flight transactions; nothing is replayed.
  - After release, in_ready=1 and out_valid=0.
- Pipeline: two register stages.
  - S1 captures operands and controls, and computes per-lane raw sum and carry-out.
  - S2 applies saturation and flags, and drives result/ovf_flags/out_valid.
  - Latency is exactly 2 cycles from the in_valid&&in_ready edge to out_valid, when out_ready=1.
  - Throughput is 1 transaction per cycle.
- Handshake:
  - Input transfer occurs when in_valid&&in_ready; output transfer occurs when out_valid&&out_ready.
  - S2 advance = !s2_valid || out_ready.
  - S1 advance = !s1_valid || S2 advance.
  - in_ready = S1 advance (combinational, no in_valid dependency).
  - While out_valid=1 and out_ready=0, result/ovf_flags/out_valid hold stable.
  - Up to 2 transactions may be buffered; none dropped or duplicated.
  - Simultaneous input and output transfers with both stages full proceed in the same cycle.
- Lanes: lane width W = 8<<data_mode; lane count = SIMD_DATA_WIDTH/W.
  - Lane i occupies bits [(i+1)W-1 : iW].
  - No carry crosses a lane boundary.
- Arithmetic per lane:
  - Add: a+b.
  - Sub: a+~b+1.
  - Result width is W; wrapped value is the low W bits.
- Overflow:
  - Unsigned add: carry-out=1.
  - Unsigned sub: borrow, i.e. a<b unsigned.
  - Signed add: a,b same sign and result sign differs.
  - Signed sub: a,b signs differ and result sign differs from a.
- Saturation (saturate=1, lane overflowed):
  - Unsigned add -> all ones; unsigned sub -> 0.
  - Signed -> max positive (0111..) if a is non-negative, else min negative (1000..).
  - Non-overflowed lanes are unchanged.
- ovf_flags:
  - Bit (i*W/8) is set for each overflowed lane i, i.e. the lowest byte of that lane. All other bits are 0.
  - Flags are reported whether or not saturation is applied.
- Mode sampling: data_mode/data_signed/op_sub/saturate are sampled with operands and travel with the transaction. Consecutive transactions may use different modes.
- No illegal data_mode values exist; all four encodings are defined.

Test Plan:
- Reset then single txn: mode 0, unsigned, add, wrap, all bytes a=0xFF, b=0x01 -> 2 cycles later out_valid=1, result all 0x00, ovf_flags all ones.
- Saturating: mode 0, unsigned, add, saturate, lane0 a=0xF0, b=0x20 -> lane0 0xFF, flag bit0=1. Same operands signed: 0xF0+0x20=0x10, no flag.
- Signed 16-bit sub: saturate, lane0 a=0x8000, b=0x0001 -> 0x8000, flag bit0=1. Lane1 a=0x7FFF, b=0xFFFF -> 0x7FFF, flag bit2=1. Wrap mode gives 0x7FFF and 0x8000 with the same flags.
- 64-bit lane isolation: mode 3, a lane0=0xFFFF_FFFF_FFFF_FFFF, b lane0=1, lane1 a=b=0 -> lane0=0, flag bit0=1, lane1=0, flag bit8=0.
- Backpressure: 5 back-to-back txns with out_ready held 0 for 4 cycles -> in_ready drops after 2 accepted, outputs stable while stalled, all 5 results in order after release with no loss or duplicates.
- Reset mid-stream: assert rst_n low with both stages full -> out_valid=0 immediately (async), result=0. After release, first new txn appears 2 cycles after acceptance.
